aes_ctr_ctrl: RTL and testbench
===============================

Name: aes_ctr_ctrl

Overview:
- Counter-mode (CTR) controller placed directly in front of aes_cipher_top.
- Builds counter blocks from a loaded IV and drives the core's ld/key/text_in.
- Captures the keystream from text_out when the core signals done, XORs it with incoming 128-bit data blocks, and returns results over a valid/ready stream.
- One core operation per block. No overlap between blocks.

Parameters:
- CTR_W, 32: width of the incrementing counter field. It occupies the low CTR_W bits of the 128-bit counter block. Legal range 8..128.
- CNT_W, 16: width of the block-count input.
- TIMEOUT_CYCLES, 64: watchdog limit in clk cycles. Used only when AES_CTR_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; samples cfg_key, cfg_iv, blk_cnt
- cfg_key  in  128  AES-128 key
- cfg_iv  in  128  initial counter block
- blk_cnt  in  CNT_W  number of blocks to process
- in_valid  in  1  input data block valid
- in_ready  out  1  controller accepts input block
- in_data  in  128  plaintext or ciphertext block
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  128  in_data XOR keystream
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the job completes
- err  out  1  sticky watchdog error flag (constant 0 without the macro)
- core_ld  out  1  to aes_cipher_top ld
- core_key  out  128  to aes_cipher_top key
- core_text_in  out  128  to aes_cipher_top text_in
- core_text_out  in  128  from aes_cipher_top text_out
- core_done  in  1  from aes_cipher_top done, treated as a pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0, including core_key, core_text_in, out_data and err. Internal counter, remaining count and keystream registers are cleared. The core shares the same rst.
- Reset mid-operation: the job is abandoned. No done pulse is issued and any result not yet accepted is lost.

State machine, one transition per clk edge:
- IDLE:
  - start=1 with blk_cnt!=0: latch key_q=cfg_key, ctr_q=cfg_iv, rem_q=blk_cnt; go to LOAD.
  - start=1 with blk_cnt==0: pulse done on the next cycle and stay in IDLE.
- LOAD: core_ld=1 for exactly this one cycle, with core_text_in=ctr_q; go to WAIT_CORE.
- WAIT_CORE:
  - On core_done=1: ks_q=core_text_out.
  - The low CTR_W bits of ctr_q increment modulo 2^CTR_W. Bits [127:CTR_W] never change, including at wrap.
  - Go to WAIT_DATA.
- WAIT_DATA:
  - in_ready=1 only in this state.
  - On in_valid=1: out_data=in_data^ks_q and out_valid=1; go to OUT.
- OUT:
  - out_valid is held high with out_data stable until out_ready=1.
  - On that handshake: out_valid=0 and rem_q decrements.
  - If the new rem_q==0: go to IDLE and pulse done in the same cycle as the return to IDLE. Otherwise go to LOAD.

Persistent signal rules:
- core_key = key_q, held stable for the whole job.
- core_text_in holds its last value outside LOAD.

Ignored or spurious inputs:
- start while busy=1: ignored.
- core_done outside WAIT_CORE: ignored.
- in_valid outside WAIT_DATA: not accepted.

Latency:
- start edge to core_ld high: 1 cycle.
- core_done to in_ready high: 1 cycle.
- in_valid/in_ready handshake to out_valid: 1 cycle.

Optional Feature:
- Macro AES_CTR_TIMEOUT_EN.
- When defined:
  - A cycle counter starts on entry to WAIT_CORE.
  - If TIMEOUT_CYCLES elapse with no core_done, err is set to 1. It is sticky and cleared only by rst.
  - The state goes to IDLE with no done pulse, and busy drops.
  - A later start is honoured even while err=1.
- When undefined: err is tied to 0 and WAIT_CORE waits indefinitely.

Test Plan:
- NIST SP800-38A F.5.1, 2 blocks:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, blk_cnt=2, data 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51.
  - Required: out_data 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff.
  - Required: second core_text_in = f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
  - Required: one done pulse, then busy=0.
- Counter wrap:
  - Stimulus: iv low 32 bits ffffffff with upper 96 bits 0123456789abcdef01234567, CTR_W=32, blk_cnt=2.
  - Required: second core_text_in = 0123456789abcdef0123456700000000.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles.
  - Required: out_valid=1 and out_data stable throughout, no second core_ld, in_ready=0.
  - Required: after out_ready=1, the next core_ld occurs 1 cycle after the handshake.
- Zero-length job and start while busy:
  - Stimulus: start with blk_cnt=0.
  - Required: done high exactly 1 cycle later, core_ld never asserted.
  - Stimulus: start pulsed during WAIT_CORE.
  - Required: no effect on ctr_q or rem_q.
- Reset mid-job:
  - Stimulus: rst=0 during OUT.
  - Required: out_valid, busy, core_ld and done go to 0 immediately (asynchronous).
  - Required: after rst=1, a fresh F.5.1 job passes.
- Watchdog, with AES_CTR_TIMEOUT_EN and a core model that never asserts done:
  - Required: err=1 and busy=0 after 64 cycles in WAIT_CORE, no done pulse.
  - Required: err stays 1 across a following successful job.

Source files
------------

// File: rtl/aes_ctr_ctrl.sv
// rtl/aes_ctr_ctrl.sv - CTR-mode controller in front of aes_cipher_top; optional watchdog under AES_CTR_TIMEOUT_EN
module aes_ctr_ctrl #(
  parameter int CTR_W          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_iv,
  input  logic [CNT_W-1:0] blk_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_ld,
  output logic [127:0]     core_key,
  output logic [127:0]     core_text_in,
  input  logic [127:0]     core_text_out,
  input  logic             core_done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_CORE = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_OUT       = 3'd4;

  // Bits covered by the incrementing counter field; the rest of the block is fixed per job.
  localparam logic [127:0] CTR_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                     : ((128'd1 << CTR_W) - 128'd1);

  logic [2:0]       state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     ctr_q, ctr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [127:0]     ks_q, ks_d;
  logic [127:0]     text_q, text_d;
  logic [127:0]     out_q, out_d;
  logic             done_q, done_d;
  logic [127:0]     ctr_inc;
  logic             tmo_hit;

  // Increment only the low CTR_W bits, letting them wrap without carrying into the upper bits.
  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

`ifdef AES_CTR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  assign tmo_hit = (state_q == S_WAIT_CORE) && !core_done &&
                   (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: count cycles spent in WAIT_CORE, restarting from zero on every entry.
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT_CORE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    err_d = err_q | tmo_hit;
  end

  // Watchdog registers; err is sticky until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state and datapath decisions for the one-block-at-a-time job sequencer.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    ks_d    = ks_q;
    text_d  = text_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (blk_cnt != '0) begin
            key_d   = cfg_key;
            ctr_d   = cfg_iv;
            rem_d   = blk_cnt;
            text_d  = cfg_iv;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core_done) begin
          ks_d    = core_text_out;
          ctr_d   = ctr_inc;
          state_d = S_WAIT_DATA;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (in_valid) begin
          out_d   = in_data ^ ks_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // The counter was already advanced when the keystream was captured.
            text_d  = ctr_q;
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      ks_q    <= '0;
      text_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      ks_q    <= ks_d;
      text_q  <= text_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign in_ready     = (state_q == S_WAIT_DATA);
  assign out_valid    = (state_q == S_OUT);
  assign out_data     = out_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign core_ld      = (state_q == S_LOAD);
  assign core_key     = key_q;
  assign core_text_in = text_q;

endmodule

// File: tb/tb_aes_ctr_ctrl.sv
// tb/tb_aes_ctr_ctrl.sv - self-checking bench for aes_ctr_ctrl with a behavioural core model
module tb_aes_ctr_ctrl;

  localparam int CTR_W          = 32;
  localparam int CNT_W          = 16;
  localparam int TIMEOUT_CYCLES = 64;

  localparam logic [127:0] F51_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F51_IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] F51_C1  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] F51_KS0 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] F51_KS1 = 128'h362b7c3c6773516318a077d7fc5073ae;

  logic             clk;
  logic             rst;
  logic             start;
  logic [127:0]     cfg_key;
  logic [127:0]     cfg_iv;
  logic [CNT_W-1:0] blk_cnt;
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             busy;
  logic             done;
  logic             err;
  logic             core_ld;
  logic [127:0]     core_key;
  logic [127:0]     core_text_in;
  logic [127:0]     core_text_out;
  logic             core_done;

  aes_ctr_ctrl #(.CTR_W(CTR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .blk_cnt(blk_cnt), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .done(done), .err(err), .core_ld(core_ld), .core_key(core_key),
    .core_text_in(core_text_in), .core_text_out(core_text_out), .core_done(core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] din_q[$];
  logic [127:0] exp_out_q[$];
  logic [127:0] exp_ctr_q[$];
  logic [127:0] ld_log[$];
  bit core_hang = 1'b0;
  bit core_spur = 1'b0;
  int ld_count  = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    int           n;
    logic [127:0] d0;
    logic [127:0] d1;
    logic [127:0] e0;
    logic [127:0] e1;
    logic [127:0] ctr1;
  } vec_t;

  vec_t tbl[2];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for AES: exact NIST keystream for the F.5.1 blocks, an arbitrary mixing function otherwise.
  function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
    if (k == F51_KEY && t == F51_IV) return F51_KS0;
    if (k == F51_KEY && t == F51_C1) return F51_KS1;
    return {t[63:0], t[127:64]} ^ k ^ {t[126:0], t[127]} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  // Counter block i of a job: iv plus i in the low CTR_W bits, modulo 2^CTR_W.
  function automatic logic [127:0] ctr_at(input logic [127:0] iv, input int i);
    logic [127:0] r;
    r = iv;
    r[CTR_W-1:0] = iv[CTR_W-1:0] + CTR_W'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic prep_random(input logic [127:0] key, input logic [127:0] iv, input int n);
    logic [127:0] d;
    logic [127:0] c;
    din_q.delete();
    exp_out_q.delete();
    exp_ctr_q.delete();
    for (int i = 0; i < n; i++) begin
      d = rand128();
      c = ctr_at(iv, i);
      din_q.push_back(d);
      exp_ctr_q.push_back(c);
      exp_out_q.push_back(d ^ fake_aes(key, c));
    end
  endtask

  // Core model: answers each core_ld after 1..4 cycles, optionally never, optionally with stray done pulses.
  initial begin : core_model
    int lat;
    logic [127:0] ks;
    core_done     = 1'b0;
    core_text_out = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (rst && core_ld) begin
        ld_count++;
        ld_log.push_back(core_text_in);
        if (exp_ctr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_core_ld: got text_in %h expected no load", core_text_in);
        end else begin
          chk("core_text_in", core_text_in, exp_ctr_q.pop_front());
        end
        if (!core_hang) begin
          lat = $urandom_range(1, 4);
          ks  = fake_aes(core_key, core_text_in);
          repeat (lat) @(posedge clk);
          #1;
          core_done     = 1'b1;
          core_text_out = ks;
        end
      end else if (core_spur && $urandom_range(0, 5) == 0) begin
        core_done     = 1'b1;
        core_text_out = rand128();
      end
    end
  end

  // mode 0: plain, 1: 10-cycle backpressure on first result, 2: start during WAIT_CORE, 3: reset during OUT
  task automatic run_job(input logic [127:0] key, input logic [127:0] iv, input int n,
                         input int mode, input string tag);
    int idx = 0;
    int oidx = 0;
    int dones = 0;
    int cyc;
    int spur_st = 0;
    int stall_bad;
    bit bp_done = 1'b0;
    bit hs_hold = 1'b0;
    bit expect_ld = 1'b0;
    logic [127:0] held;
    start   = 1'b1;
    cfg_key = key;
    cfg_iv  = iv;
    blk_cnt = CNT_W'(n);
    @(negedge clk);
    start   = 1'b0;
    cfg_key = rand128();
    cfg_iv  = rand128();
    blk_cnt = CNT_W'($urandom);
    chk({tag, "_start_to_ld"}, 128'(core_ld), 128'd1);
    for (cyc = 0; cyc < 2000; cyc++) begin
      if (expect_ld) begin
        chk({tag, "_ld_after_handshake"}, 128'(core_ld), 128'd1);
        expect_ld = 1'b0;
      end
      if (done) dones++;
      if (mode == 3 && out_valid) begin
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_async_reset_outputs"}, 128'({out_valid, busy, core_ld, done}), 128'd0);
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din_q.delete();
        exp_out_q.delete();
        exp_ctr_q.delete();
        return;
      end
      if (mode == 1 && out_valid && !bp_done) begin
        held      = out_data;
        out_ready = 1'b0;
        stall_bad = 0;
        repeat (10) begin
          @(negedge clk);
          if (!out_valid || out_data !== held || in_ready || core_ld) stall_bad++;
        end
        chk({tag, "_stall_violations"}, 128'(stall_bad), 128'd0);
        out_ready = 1'b1;
        bp_done   = 1'b1;
        hs_hold   = 1'b1;
      end else begin
        out_ready = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      end
      if (out_valid && out_ready) begin
        if (exp_out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra_output: got %h expected none", tag, out_data);
        end else begin
          chk({tag, "_out_data"}, out_data, exp_out_q.pop_front());
        end
        oidx++;
        if (hs_hold && oidx < n) expect_ld = 1'b1;
        hs_hold = 1'b0;
      end
      if (mode == 2) begin
        if (spur_st == 0 && core_ld) begin
          spur_st = 1;
        end else if (spur_st == 1) begin
          start   = 1'b1;
          cfg_iv  = ~iv;
          blk_cnt = CNT_W'(7);
          spur_st = 2;
        end else if (spur_st == 2) begin
          start   = 1'b0;
          spur_st = 3;
        end
      end
      if (idx < n) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = in_valid ? din_q[idx] : rand128();
        if (in_valid && in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      if (!busy) break;
      @(negedge clk);
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (cyc >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected job end", tag, cyc);
    end
    chk({tag, "_done_pulses"}, 128'(dones), 128'd1);
    chk({tag, "_blocks_out"}, 128'(oidx), 128'(n));
    chk({tag, "_loads_left"}, 128'(exp_ctr_q.size()), 128'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, 128'({done, busy}), 128'd0);
  endtask

  initial begin : main
    int ld0;
    int wc;
    int dn;
    logic [127:0] key;
    logic [127:0] iv;
    int n;

    tbl[0] = '{key: F51_KEY, iv: F51_IV, n: 2,
               d0: 128'h6bc1bee22e409f96e93d7e117393172a,
               d1: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
               e0: 128'h874d6191b620e3261bef6864990db6ce,
               e1: 128'h9806f66b7970fdff8617187bb9fffdff,
               ctr1: F51_C1};
    tbl[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
               iv: 128'h0123456789abcdef01234567ffffffff, n: 2,
               d0: 128'h0, d1: 128'h0,
               e0: fake_aes(128'h000102030405060708090a0b0c0d0e0f,
                            128'h0123456789abcdef01234567ffffffff),
               e1: fake_aes(128'h000102030405060708090a0b0c0d0e0f,
                            128'h0123456789abcdef0123456700000000),
               ctr1: 128'h0123456789abcdef0123456700000000};

    rst = 1'b1;
    start = 1'b0;
    cfg_key = '0;
    cfg_iv = '0;
    blk_cnt = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 128'({in_ready, out_valid, busy, done, err, core_ld}), 128'd0);
    chk("reset_core_key", core_key, 128'd0);
    chk("reset_core_text_in", core_text_in, 128'd0);
    chk("reset_out_data", out_data, 128'd0);
    rst = 1'b1;
    @(negedge clk);

    ld0 = ld_count;
    start = 1'b1;
    blk_cnt = '0;
    cfg_iv = rand128();
    @(negedge clk);
    start = 1'b0;
    chk("zero_len_done", 128'({done, busy}), 128'b10);
    @(negedge clk);
    chk("zero_len_done_once", 128'(done), 128'd0);
    chk("zero_len_no_ld", 128'(ld_count - ld0), 128'd0);

    for (int i = 0; i < 2; i++) begin
      din_q.delete();
      exp_out_q.delete();
      exp_ctr_q.delete();
      ld_log.delete();
      din_q.push_back(tbl[i].d0);
      din_q.push_back(tbl[i].d1);
      exp_out_q.push_back(tbl[i].e0);
      exp_out_q.push_back(tbl[i].e1);
      exp_ctr_q.push_back(tbl[i].iv);
      exp_ctr_q.push_back(ctr_at(tbl[i].iv, 1));
      run_job(tbl[i].key, tbl[i].iv, tbl[i].n, (i == 0) ? 1 : 0, (i == 0) ? "vec_f51" : "vec_wrap");
      chk((i == 0) ? "vec_f51_ctr1" : "vec_wrap_ctr1",
          (ld_log.size() > 1) ? ld_log[1] : 128'd0, tbl[i].ctr1);
    end

    core_spur = 1'b1;
    key = rand128();
    iv = rand128();
    prep_random(key, iv, 3);
    run_job(key, iv, 3, 2, "start_while_busy");

    for (int j = 0; j < 10; j++) begin
      core_spur = ($urandom_range(0, 1) == 1);
      key = rand128();
      iv = rand128();
      if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hffffffff - 32'($urandom_range(0, 2));
      n = $urandom_range(1, 4);
      prep_random(key, iv, n);
      run_job(key, iv, n, 0, "random");
    end
    core_spur = 1'b0;

    key = rand128();
    iv = rand128();
    prep_random(key, iv, 2);
    run_job(key, iv, 2, 3, "reset_mid_job");
    din_q = '{tbl[0].d0, tbl[0].d1};
    exp_out_q = '{tbl[0].e0, tbl[0].e1};
    exp_ctr_q = '{F51_IV, F51_C1};
    run_job(F51_KEY, F51_IV, 2, 0, "after_reset_f51");

`ifdef AES_CTR_TIMEOUT_EN
    core_hang = 1'b1;
    exp_ctr_q.delete();
    exp_ctr_q.push_back(F51_IV);
    start = 1'b1;
    cfg_key = F51_KEY;
    cfg_iv = F51_IV;
    blk_cnt = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    wc = 0;
    dn = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) dn++;
      if (!busy) break;
      if (!core_ld) wc++;
      @(negedge clk);
    end
    chk("wd_wait_cycles", 128'(wc), 128'(TIMEOUT_CYCLES));
    chk("wd_err_idle", 128'({err, busy}), 128'b10);
    chk("wd_no_done", 128'(dn), 128'd0);
    core_hang = 1'b0;
    @(negedge clk);
    din_q = '{tbl[0].d0, tbl[0].d1};
    exp_out_q = '{tbl[0].e0, tbl[0].e1};
    exp_ctr_q = '{F51_IV, F51_C1};
    run_job(F51_KEY, F51_IV, 2, 0, "after_wd_f51");
    chk("wd_err_sticky", 128'(err), 128'd1);
`else
    wc = 0;
    dn = 0;
    chk("err_tied_low", 128'(err), 128'(wc + dn));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
